// File: rtl/sp_ram_pkg.sv
// Shared constants and types for the byte-enable single-port RAM.
// Read-during-write mode codes, FSM state type and address-width helper.
package sp_ram_pkg;

    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;
    localparam int RDW_NO_CHANGE   = 2;

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } state_e;

    // Address width for a given depth, never narrower than one bit.
    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/sp_ram_be_if.sv
// Access bus between a local master and the sp_ram_be block.
// The slave modport belongs to the RAM; the master modport belongs to the requester.
interface sp_ram_be_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64
);
    localparam int AW = sp_ram_pkg::addr_w(DEPTH);
    localparam int NB = DATA_W / 8;

    logic              en;
    logic              we;
    logic [NB-1:0]     be;
    logic [AW-1:0]     addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;
    logic              addr_err;
    logic              clr_req;
    logic              busy;

    modport master (
        output en, we, be, addr, wdata, clr_req,
        input  rdata, rvalid, addr_err, busy
    );

    modport slave (
        input  en, we, be, addr, wdata, clr_req,
        output rdata, rvalid, addr_err, busy
    );

endinterface

// File: rtl/sp_ram_array.sv
// Plain storage array: byte-enable synchronous write, registered read.
// The read returns the word as it was before any write in the same cycle.
module sp_ram_array
    import sp_ram_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64
) (
    input  logic                        clk,
    input  logic                        we_i,
    input  logic [DATA_W/8-1:0]         be_i,
    input  logic [addr_w(DEPTH)-1:0]    addr_i,
    input  logic [DATA_W-1:0]           wdata_i,
    output logic [DATA_W-1:0]           rdata_o
);
    localparam int NB = DATA_W / 8;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        rdata_q <= mem[addr_i];
        if (we_i) begin
            for (int i = 0; i < NB; i++) begin
                if (be_i[i]) begin
                    mem[addr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
                end
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sp_ram_be.sv
// Parametrised single-port RAM with byte enables, selectable read-during-write
// behaviour, optional output register, range checking and a zeroing engine.
module sp_ram_be
    import sp_ram_pkg::*;
#(
    parameter int DATA_W        = 32,
    parameter int DEPTH         = 64,
    parameter int RDW_MODE      = 0,
    parameter int OUT_REG       = 0,
    parameter int INIT_ON_RESET = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    sp_ram_be_if.slave    bus
);
    localparam int              AW        = addr_w(DEPTH);
    localparam int              NB        = DATA_W / 8;
    localparam logic [AW-1:0]   LAST      = AW'(DEPTH - 1);
    localparam state_e          RST_STATE = (INIT_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;

    state_e            state_q, state_d;
    logic [AW-1:0]     cnt_q, cnt_d;
    logic              busy, acc, in_range;
    logic              arr_we;
    logic [NB-1:0]     arr_be;
    logic [AW-1:0]     arr_addr;
    logic [DATA_W-1:0] arr_wdata, arr_rdata;

    assign busy     = (state_q == ST_CLEAR);
    assign acc      = bus.en & ~busy;
    assign bus.busy = busy;

    // A power-of-two depth covers every address, so no compare is built.
    if ((1 << AW) == DEPTH) begin : g_pow2
        assign in_range = 1'b1;
    end else begin : g_range
        assign in_range = ({1'b0, bus.addr} < (AW+1)'(DEPTH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RST_STATE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.clr_req) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            ST_CLEAR: begin
                if (cnt_q == LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The clear engine owns the array port for as long as it runs.
    always_comb begin
        arr_we    = acc & bus.we & in_range;
        arr_be    = bus.be;
        arr_addr  = bus.addr;
        arr_wdata = bus.wdata;
        if (busy) begin
            arr_we    = 1'b1;
            arr_be    = '1;
            arr_addr  = cnt_q;
            arr_wdata = '0;
        end
    end

    sp_ram_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk     (clk),
        .we_i    (arr_we),
        .be_i    (arr_be),
        .addr_i  (arr_addr),
        .wdata_i (arr_wdata),
        .rdata_o (arr_rdata)
    );

    logic              s1_rsp_q, s1_err_q, s1_merge_q;
    logic [NB-1:0]     s1_be_q;
    logic [DATA_W-1:0] s1_wdata_q;
    logic [DATA_W-1:0] s1_mask, s1_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_rsp_q   <= 1'b0;
            s1_err_q   <= 1'b0;
            s1_merge_q <= 1'b0;
            s1_be_q    <= '0;
            s1_wdata_q <= '0;
        end else begin
            s1_rsp_q   <= acc & (~bus.we | (RDW_MODE != RDW_NO_CHANGE));
            s1_err_q   <= acc & ~in_range;
            s1_merge_q <= acc & bus.we & (RDW_MODE == RDW_WRITE_FIRST);
            s1_be_q    <= bus.be;
            s1_wdata_q <= bus.wdata;
        end
    end

    for (genvar gi = 0; gi < NB; gi++) begin : g_mask
        assign s1_mask[gi*8 +: 8] = {8{s1_be_q[gi]}};
    end

    // Array output is the pre-write word; WRITE_FIRST overlays the new lanes here.
    always_comb begin
        s1_data = arr_rdata;
        if (s1_err_q) begin
            s1_data = '0;
        end else if (s1_merge_q) begin
            s1_data = (arr_rdata & ~s1_mask) | (s1_wdata_q & s1_mask);
        end
    end

    if (OUT_REG != 0) begin : g_oreg
        logic [DATA_W-1:0] rdata_q;
        logic              rvalid_q, err_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rdata_q  <= '0;
                rvalid_q <= 1'b0;
                err_q    <= 1'b0;
            end else begin
                if (s1_rsp_q) rdata_q <= s1_data;
                rvalid_q <= s1_rsp_q;
                err_q    <= s1_err_q;
            end
        end

        assign bus.rdata    = rdata_q;
        assign bus.rvalid   = rvalid_q;
        assign bus.addr_err = err_q;
    end else begin : g_noreg
        logic [DATA_W-1:0] hold_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                hold_q <= '0;
            end else if (s1_rsp_q) begin
                hold_q <= s1_data;
            end
        end

        assign bus.rdata    = s1_rsp_q ? s1_data : hold_q;
        assign bus.rvalid   = s1_rsp_q;
        assign bus.addr_err = s1_err_q;
    end

endmodule

// File: tb/tb_sp_ram_be.sv
// Bench for sp_ram_be: three configurations driven by shared stimulus, each
// checked every cycle against a word-level memory model plus literal checks.
module tb_sp_ram_be;
    import sp_ram_pkg::*;

    localparam int NDUT = 3;

    function automatic int cfg_depth(input int i);
        return (i == 1) ? 48 : 64;
    endfunction
    function automatic int cfg_mode(input int i);
        return (i == 0) ? RDW_READ_FIRST : (i == 1) ? RDW_WRITE_FIRST : RDW_NO_CHANGE;
    endfunction
    function automatic int cfg_oreg(input int i);
        return (i == 1) ? 1 : 0;
    endfunction

    typedef struct packed {
        logic        v;
        logic        e;
        logic [31:0] d;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0, we = 1'b0, clr_req = 1'b0;
    logic [3:0]  be = '0;
    logic [5:0]  addr = '0;
    logic [31:0] wdata = '0;

    always #5 clk = ~clk;

    logic        busy_w [NDUT];
    logic        rvalid_w [NDUT];
    logic        err_w [NDUT];
    logic [31:0] rdata_w [NDUT];
    logic        exp_busy_w [NDUT];
    logic        exp_v_w [NDUT];
    logic        exp_e_w [NDUT];
    logic [31:0] exp_d_w [NDUT];

    int checks = 0;
    int errors = 0;

    for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
        localparam int DEPTH = cfg_depth(gi);
        localparam int MODE  = cfg_mode(gi);
        localparam int OREG  = cfg_oreg(gi);

        sp_ram_be_if #(.DATA_W(32), .DEPTH(DEPTH)) u_if ();

        assign u_if.en      = en;
        assign u_if.we      = we;
        assign u_if.be      = be;
        assign u_if.addr    = addr;
        assign u_if.wdata   = wdata;
        assign u_if.clr_req = clr_req;

        sp_ram_be #(
            .DATA_W        (32),
            .DEPTH         (DEPTH),
            .RDW_MODE      (MODE),
            .OUT_REG       (OREG),
            .INIT_ON_RESET (1)
        ) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (u_if.slave)
        );

        assign busy_w[gi]   = u_if.busy;
        assign rvalid_w[gi] = u_if.rvalid;
        assign err_w[gi]    = u_if.addr_err;
        assign rdata_w[gi]  = u_if.rdata;

        // Model: a clear zeroes the whole array at once and then blocks access
        // for DEPTH cycles; responses travel through a queue of OREG+1 slots.
        logic [31:0] mem_m [64];
        int          clr_left;
        rsp_t        pipe [$];
        rsp_t        cur;

        always @(posedge clk) begin : b_model
            rsp_t        r;
            logic [31:0] old_w, new_w;
            bit          busy_now, oor;
            r = '0;
            if (!rst_n) begin
                clr_left = DEPTH;
                for (int k = 0; k < 64; k++) mem_m[k] = '0;
                pipe.delete();
                for (int k = 0; k < OREG; k++) pipe.push_back(rsp_t'(0));
                cur = '0;
            end else begin
                busy_now = (clr_left > 0);
                if (busy_now) begin
                    clr_left = clr_left - 1;
                end else if (en) begin
                    oor   = (int'(addr) >= DEPTH);
                    old_w = oor ? 32'h0 : mem_m[addr];
                    r.e   = oor;
                    if (!we) begin
                        r.v = 1'b1;
                        r.d = old_w;
                    end else begin
                        new_w = old_w;
                        for (int k = 0; k < 4; k++)
                            if (be[k]) new_w[k*8 +: 8] = wdata[k*8 +: 8];
                        if (!oor) mem_m[addr] = new_w;
                        if (MODE != RDW_NO_CHANGE) begin
                            r.v = 1'b1;
                            r.d = oor ? 32'h0 : ((MODE == RDW_READ_FIRST) ? old_w : new_w);
                        end
                    end
                end
                if (!busy_now && clr_req) begin
                    clr_left = DEPTH;
                    for (int k = 0; k < 64; k++) mem_m[k] = '0;
                end
                pipe.push_back(r);
                if (pipe.size() > OREG) begin
                    r     = pipe.pop_front();
                    cur.v = r.v;
                    cur.e = r.e;
                    if (r.v) cur.d = r.d;
                end
            end
        end

        assign exp_busy_w[gi] = (clr_left > 0);
        assign exp_v_w[gi]    = cur.v;
        assign exp_e_w[gi]    = cur.e;
        assign exp_d_w[gi]    = cur.d;
    end

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%08h required=%08h", name, act, exp);
        end
    endtask

    // Every cycle passes through here: outputs are compared against the model.
    task automatic neg();
        @(negedge clk);
        if (rst_n) begin
            for (int i = 0; i < NDUT; i++) begin
                chk1($sformatf("model_busy[%0d]", i), busy_w[i], exp_busy_w[i]);
                chk1($sformatf("model_rvalid[%0d]", i), rvalid_w[i], exp_v_w[i]);
                chk1($sformatf("model_addr_err[%0d]", i), err_w[i], exp_e_w[i]);
                chk32($sformatf("model_rdata[%0d]", i), rdata_w[i], exp_d_w[i]);
            end
        end
    endtask

    task automatic acc(input logic w, input logic [3:0] b, input logic [5:0] a,
                       input logic [31:0] d, input logic c);
        en = 1'b1; we = w; be = b; addr = a; wdata = d; clr_req = c;
        neg();
        en = 1'b0; we = 1'b0; be = '0; clr_req = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        for (int i = 0; i < NDUT; i++) begin
            chk1($sformatf("%s_rst_rvalid[%0d]", tag, i), rvalid_w[i], 1'b0);
            chk1($sformatf("%s_rst_addr_err[%0d]", tag, i), err_w[i], 1'b0);
            chk32($sformatf("%s_rst_rdata[%0d]", tag, i), rdata_w[i], 32'h0);
            chk1($sformatf("%s_rst_busy[%0d]", tag, i), busy_w[i], 1'b1);
        end
    endtask

    // Counts clear cycles from reset release until busy drops.
    task automatic count_busy(input string tag);
        int n [NDUT];
        for (int i = 0; i < NDUT; i++) n[i] = busy_w[i] ? 1 : 0;
        repeat (90) begin
            neg();
            for (int i = 0; i < NDUT; i++) if (busy_w[i]) n[i]++;
        end
        for (int i = 0; i < NDUT; i++)
            chk32($sformatf("%s_busy_len[%0d]", tag, i), 32'(n[i]), 32'(cfg_depth(i)));
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy_w[0] | busy_w[1] | busy_w[2]) && n < 100) begin
            neg();
            n++;
        end
        chk1("wait_idle_timeout", busy_w[0] | busy_w[1] | busy_w[2], 1'b0);
    endtask

    initial begin
        repeat (3) neg();
        check_reset("init");
        rst_n = 1'b1;
        count_busy("init");

        acc(1'b0, 4'h0, 6'd63, 32'h0, 1'b0);
        chk1("rd63_rvalid", rvalid_w[0], 1'b1);
        chk32("rd63_rdata", rdata_w[0], 32'h0000_0000);

        acc(1'b1, 4'b1111, 6'd5, 32'hDEAD_BEEF, 1'b0);
        acc(1'b1, 4'b0101, 6'd5, 32'h1122_3344, 1'b0);
        neg();
        acc(1'b0, 4'h0, 6'd5, 32'h0, 1'b0);
        chk1("be_rvalid_lat1", rvalid_w[0], 1'b1);
        chk32("be_rdata_lat1", rdata_w[0], 32'hDE22_BE44);
        chk1("be_oreg_not_yet", rvalid_w[1], 1'b0);
        neg();
        chk1("be_oreg_rvalid", rvalid_w[1], 1'b1);
        chk32("be_oreg_rdata", rdata_w[1], 32'hDE22_BE44);

        acc(1'b1, 4'b1111, 6'd7, 32'hAAAA_AAAA, 1'b0);
        neg();
        acc(1'b1, 4'b0011, 6'd7, 32'h5555_5555, 1'b0);
        chk1("rdw_rf_rvalid", rvalid_w[0], 1'b1);
        chk32("rdw_rf_rdata", rdata_w[0], 32'hAAAA_AAAA);
        chk1("rdw_nc_rvalid", rvalid_w[2], 1'b0);
        chk32("rdw_nc_rdata", rdata_w[2], 32'hDE22_BE44);
        neg();
        chk1("rdw_wf_rvalid", rvalid_w[1], 1'b1);
        chk32("rdw_wf_rdata", rdata_w[1], 32'hAAAA_5555);

        acc(1'b0, 4'h0, 6'd50, 32'h0, 1'b0);
        neg();
        chk1("oor_rvalid", rvalid_w[1], 1'b1);
        chk1("oor_addr_err", err_w[1], 1'b1);
        chk32("oor_rdata", rdata_w[1], 32'h0);
        acc(1'b1, 4'b1111, 6'd50, 32'h1234_5678, 1'b0);
        acc(1'b0, 4'h0, 6'd2, 32'h0, 1'b0);
        neg();
        chk1("alias_rvalid", rvalid_w[1], 1'b1);
        chk1("alias_addr_err", err_w[1], 1'b0);
        chk32("alias_rdata", rdata_w[1], 32'h0);

        acc(1'b1, 4'b1111, 6'd3, 32'h0000_0001, 1'b1);
        for (int i = 0; i < NDUT; i++) chk1($sformatf("clr_busy_rise[%0d]", i), busy_w[i], 1'b1);
        en = 1'b1; we = 1'b0; addr = 6'd3;
        repeat (5) begin
            neg();
            chk1("busy_read_dropped", rvalid_w[0], 1'b0);
        end
        en = 1'b0;
        wait_idle();
        acc(1'b0, 4'h0, 6'd3, 32'h0, 1'b0);
        chk1("post_clr_rvalid", rvalid_w[0], 1'b1);
        chk32("post_clr_rdata", rdata_w[0], 32'h0);

        clr_req = 1'b1;
        neg();
        clr_req = 1'b0;
        repeat (19) neg();
        rst_n = 1'b0;
        neg();
        neg();
        check_reset("midclr");
        rst_n = 1'b1;
        count_busy("midclr");

        repeat (3000) begin
            en      = ($urandom_range(0, 3) != 0);
            we      = 1'($urandom_range(0, 1));
            be      = 4'($urandom);
            addr    = 6'($urandom_range(0, 63));
            wdata   = $urandom;
            clr_req = ($urandom_range(0, 249) == 0);
            neg();
        end
        en = 1'b0; clr_req = 1'b0;
        repeat (3) neg();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sp_ram_be.md
Name: sp_ram_be

Overview:
- Parametrised single-port synchronous RAM; next generation of the team's 8x64 single-port RAM.
- Adds the following over the fixed 8x64 part:
  - configurable width and depth
  - byte-write enables
  - selectable read-during-write mode
  - optional output register
  - read-valid strobe
  - out-of-range detection
  - hardware clear engine that zeroes the array after reset or on request
- Sits between a local master (DMA or CPU bus adapter) and on-chip block RAM.

Parameters:
- DATA_W, 32, word width in bits; must be a multiple of 8.
- DEPTH, 64, number of words; need not be a power of two.
- RDW_MODE, 0, read-during-write behaviour: 0 = READ_FIRST, 1 = WRITE_FIRST, 2 = NO_CHANGE.
- OUT_REG, 0, 1 adds an output pipeline register (read latency 2 instead of 1).
- INIT_ON_RESET, 1, 1 runs the clear engine automatically on reset release.
- AW (localparam), clog2(DEPTH), address width (minimum 1).
- NB (localparam), DATA_W/8, number of byte lanes.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  access request; accepted only when busy=0.
- we  in  1  1 = write, 0 = read; qualified by en.
- be  in  NB  byte-lane write enables; ignored on reads.
- addr  in  AW  word address.
- wdata  in  DATA_W  write data.
- rdata  out  DATA_W  read data.
- rvalid  out  1  one-cycle strobe; rdata valid this cycle.
- addr_err  out  1  one-cycle strobe; accepted access had addr >= DEPTH.
- clr_req  in  1  pulse; request zeroing of the whole array.
- busy  out  1  clear engine active; accesses are dropped.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - rdata=0, rvalid=0, addr_err=0, pipeline register cleared.
  - FSM goes to CLEAR if INIT_ON_RESET=1, else IDLE; busy=1 while the FSM is in CLEAR.
  - Clear counter = 0; array contents are not reset directly.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR on clr_req=1.
  - CLEAR writes 0 to address cnt with all byte lanes enabled, one word per cycle, cnt 0..DEPTH-1.
  - CLEAR -> IDLE in the cycle after cnt=DEPTH-1 is written; busy falls with the state change.
  - Clear duration is exactly DEPTH cycles.
- Access acceptance: an access is accepted when en=1 and busy=0. Accesses with busy=1 are dropped: no write, no rvalid, no addr_err.
- Write (accepted, we=1, addr<DEPTH): byte lane i of mem[addr] is updated iff be[i]=1. be=0 writes nothing but still counts as an accepted access.
- Read (accepted, we=0, addr<DEPTH):
  - OUT_REG=0: rdata=mem[addr] and rvalid=1 on the next edge (latency 1).
  - OUT_REG=1: latency 2.
- Write response, by RDW_MODE:
  - READ_FIRST: the write also returns rvalid with the old word.
  - WRITE_FIRST: the write also returns rvalid with the merged word (new bytes where be=1, old bytes elsewhere).
  - NO_CHANGE: no rvalid; rdata holds its previous value.
- Between responses rdata holds its last value; it is not zeroed.
- Out of range (accepted, addr >= DEPTH):
  - No array write.
  - addr_err pulses with the same latency as rvalid.
  - Reads, and writes in modes 0/1, return rvalid=1 with rdata=0.
  - addr_err is never generated when DEPTH is a power of two.
- clr_req and en in the same IDLE cycle: the access executes and its response is delivered normally; CLEAR starts on the next cycle. The access's write is later overwritten by the clear.
- clr_req while in CLEAR: ignored; the clear does not restart.
- In-flight reads: responses accepted before CLEAR entry complete normally through the pipeline while busy=1.
- rst_n asserted mid-clear: clear aborts; on release it restarts from cnt=0 if INIT_ON_RESET=1, else the array is left partially cleared and the FSM is in IDLE.
- Consecutive accesses: back-to-back accesses at full rate, one per cycle, with no bubbles.

Decomposition:
- Package sp_ram_pkg contains:
  - RDW_READ_FIRST=0, RDW_WRITE_FIRST=1, RDW_NO_CHANGE=2
  - FSM state enum {ST_IDLE, ST_CLEAR}
- Sub-module sp_ram_array: a pure storage array (parameters DATA_W, DEPTH) with synchronous byte-enable write and synchronous read, kept inferrable as block RAM. The top level owns the FSM, port muxing, RDW merge, range check and output pipeline.

Test Plan (DATA_W=32, DEPTH=64 unless stated):
- Reset release with INIT_ON_RESET=1 -> busy=1 for exactly 64 cycles; a subsequent read of addr 63 returns 0x00000000 with rvalid one cycle later.
- Write 0xDEADBEEF to addr 5 with be=4'b1111, then write 0x11223344 with be=4'b0101, then read addr 5 -> rdata=0xDE22BE44; with OUT_REG=1, rvalid arrives 2 cycles after the read.
- RDW check: mem[7]=0xAAAAAAAA, then write 0x55555555 with be=4'b0011 to addr 7:
  - RDW_MODE=0 -> rdata=0xAAAAAAAA, rvalid=1
  - RDW_MODE=1 -> rdata=0xAAAA5555, rvalid=1
  - RDW_MODE=2 -> rvalid=0, rdata unchanged
- DEPTH=48: read addr 50 -> rvalid=1, addr_err=1, rdata=0; write 0x12345678 to addr 50, then read addr 50-48=2 -> unchanged value.
- Same-cycle clr_req plus write 0x1 to addr 3 -> write accepted, busy rises the next cycle; en=1 reads during busy produce no rvalid; after busy falls, a read of addr 3 returns 0.
- Assert rst_n=0 at clear cycle 20, release -> clear restarts at cnt=0 and busy lasts a full 64 cycles.
